// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI mode-0 responder and its master counterpart.
package spi_slave_pkg;

   localparam int SPI_FRAME_SIZE  = 40;
   localparam int SPI_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin, with rise/fall pulses taken
// from the last stage against one extra registered copy.
module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign rise_o = sync_q[STAGES-1] & ~prev_q;
   assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder for fixed-length frames, oversampling the SPI pins in
// the system clock domain.
//
// state  | meaning
// IDLE   | waiting for cs fall, miso not driven
// ACTIVE | shifting: sample mosi on sck rise, advance miso on armed sck fall
// DONE   | full frame received, extra sck edges ignored until cs rises
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int SIZE        = SPI_FRAME_SIZE,
   parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [SIZE-1:0] tx_data_i,
   output logic            tx_taken_o,
   output logic [SIZE-1:0] rx_data_o,
   output logic            rx_valid_o,
   output logic            frame_err_o,
   output logic            busy_o,
   input  logic            cs_i,
   input  logic            sck_i,
   input  logic            mosi_i,
   output logic            miso_o,
   output logic            miso_oe_o
);

   localparam int              CW       = $clog2(SIZE + 1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(SIZE);

   logic cs_rise, cs_fall, sck_rise, sck_fall;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic mosi_s;

   spi_state_e      state_q, state_d;
   logic [SIZE-1:0] tx_shift_q, tx_shift_d;
   logic [SIZE-1:0] rx_shift_q, rx_shift_d;
   logic [SIZE-1:0] rx_data_q, rx_data_d;
   logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
   logic            armed_q, armed_d;
   logic            tx_taken_q, tx_taken_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            miso_q, miso_d;
   logic            miso_oe_q, miso_oe_d;
   logic            busy_q, busy_d;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (cs_i),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (sck_i),
      .rise_o (sck_rise),
      .fall_o (sck_fall)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) mosi_sync_q <= '0;
      else         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
   end
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d     = state_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      bit_cnt_d   = bit_cnt_q;
      armed_d     = armed_q;
      tx_taken_d  = 1'b0;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               tx_shift_d = tx_data_i;
               tx_taken_d = 1'b1;
               bit_cnt_d  = '0;
               armed_d    = 1'b0;
               state_d    = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            // cs rise outranks any sck edge seen in the same cycle
            if (cs_rise) begin
               if (bit_cnt_q == CNT_FULL) begin
                  rx_data_d  = rx_shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end else if (bit_cnt_q == CNT_FULL) begin
               rx_data_d  = rx_shift_q;
               rx_valid_d = 1'b1;
               state_d    = ST_DONE;
            end else if (sck_rise) begin
               rx_shift_d = {rx_shift_q[SIZE-2:0], mosi_s};
               bit_cnt_d  = bit_cnt_q + CW'(1);
               armed_d    = 1'b1;
            end else if (sck_fall && armed_q) begin
               tx_shift_d = {tx_shift_q[SIZE-2:0], 1'b0};
               armed_d    = 1'b0;
            end
         end
         ST_DONE: begin
            if (cs_rise) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      miso_d    = (state_d == ST_ACTIVE) ? tx_shift_d[SIZE-1] : 1'b0;
      miso_oe_d = (state_d != ST_IDLE);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         bit_cnt_q   <= '0;
         armed_q     <= 1'b0;
         tx_taken_q  <= 1'b0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         bit_cnt_q   <= bit_cnt_d;
         armed_q     <= armed_d;
         tx_taken_q  <= tx_taken_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
         busy_q      <= busy_d;
      end
   end

   assign tx_taken_o  = tx_taken_q;
   assign rx_data_o   = rx_data_q;
   assign rx_valid_o  = rx_valid_q;
   assign frame_err_o = frame_err_q;
   assign busy_o      = busy_q;
   assign miso_o      = miso_q;
   assign miso_oe_o   = miso_oe_q;

endmodule
